// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit and the EX-stage ALU source muxes.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package forward_hazard_unit_pkg;

    // Register-address width carried in a shadow slot; narrower REG_AW values are zero-extended.
    localparam int SLOT_AW = 8;

    // Operand source selects; the ALU source muxes decode these same values.
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;   // register-file read data
    localparam fwd_sel_t FWD_WB  = 2'b01;   // write-back data
    localparam fwd_sel_t FWD_MEM = 2'b10;   // MEM-stage result

    typedef logic [SLOT_AW-1:0] reg_addr_t;

    // Hazard-relevant fields of one in-flight instruction.
    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      use_rs1;
        logic      use_rs2;
        reg_addr_t rd;
        logic      reg_write;
        logic      mem_read;
    } slot_t;

    // True when a producer writing rd satisfies a consumer reading src; x0 never matches.
    function automatic logic producer_hit(input logic reg_write, input reg_addr_t rd,
                                          input reg_addr_t src, input logic use_src);
        return reg_write && (rd != '0) && (rd == src) && use_src;
    endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit: ID fields in, selects and stall controls out.
// Latency: n/a (wiring only).
// Backpressure: stall controls (PC_Write/IF_ID_Write/ID_EX_Bubble) are the backpressure toward IF/ID.
interface forward_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] ID_rs1;
    logic [REG_AW-1:0] ID_rs2;
    logic              ID_use_rs1;
    logic              ID_use_rs2;
    logic [REG_AW-1:0] ID_rd;
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic              EX_flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              PC_Write;
    logic              IF_ID_Write;
    logic              ID_EX_Bubble;
    logic [CNT_W-1:0]  Stall_count;

    // Pipeline side: presents the decoded instruction and consumes the controls.
    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_RegWrite, ID_MemRead, EX_flush,
        input  ForwardA, ForwardB, PC_Write, IF_ID_Write, ID_EX_Bubble, Stall_count
    );

    // Hazard unit side.
    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_RegWrite, ID_MemRead, EX_flush,
        output ForwardA, ForwardB, PC_Write, IF_ID_Write, ID_EX_Bubble, Stall_count
    );
endinterface

// File: rtl/forward_hazard_unit_fwd_select.sv
// One ALU operand source select from the MEM and WB producers of the shadow pipeline.
// Latency: combinational.
// Backpressure: none.
module fwd_select
    import forward_hazard_unit_pkg::*;
(
    input  logic      mem_reg_write,
    input  reg_addr_t mem_rd,
    input  logic      wb_reg_write,
    input  reg_addr_t wb_rd,
    input  reg_addr_t ex_src,
    input  logic      ex_use_src,
    output fwd_sel_t  sel
);

    // MEM holds the younger producer, so it is checked first and wins a double match.
    always_comb begin
        sel = FWD_RF;
        if (producer_hit(mem_reg_write, mem_rd, ex_src, ex_use_src)) begin
            sel = FWD_MEM;
        end else if (producer_hit(wb_reg_write, wb_rd, ex_src, ex_use_src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding selects and load-use stall control from a shadow EX/MEM/WB pipeline.
// Latency: outputs combinational on slot state and ID fields; slots advance every clock.
// Backpressure: one-cycle PC/IF-ID hold plus ID/EX bubble on load-use; flush overrides the hold.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    forward_hazard_unit_if.slave  bus
);

    slot_t            ex_q;
    slot_t            mem_q;
    slot_t            wb_q;
    slot_t            id_slot;
    logic             load_use;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;

    assign id_rs1 = bus.ID_rs1;
    assign id_rs2 = bus.ID_rs2;
    assign id_rd  = bus.ID_rd;

    // Pack the ID instruction into slot form, zero-extending addresses to the slot width.
    always_comb begin
        id_slot           = '0;
        id_slot.rs1       = SLOT_AW'(id_rs1);
        id_slot.rs2       = SLOT_AW'(id_rs2);
        id_slot.use_rs1   = bus.ID_use_rs1;
        id_slot.use_rs2   = bus.ID_use_rs2;
        id_slot.rd        = SLOT_AW'(id_rd);
        id_slot.reg_write = bus.ID_RegWrite;
        id_slot.mem_read  = bus.ID_MemRead;
    end

    // A load in EX whose destination the ID instruction reads cannot be forwarded in time.
    // The stall needs no state: next cycle the load is in MEM and this term drops.
    always_comb begin
        load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                   ((id_slot.use_rs1 && (id_slot.rs1 == ex_q.rd)) ||
                    (id_slot.use_rs2 && (id_slot.rs2 == ex_q.rd)));
        // A flush discards the stalled instruction anyway, so it takes precedence.
        stall    = load_use && !bus.EX_flush;
        // Gated by reset so the bubble control reads inactive while held in reset.
        bubble   = rst_n && (stall || bus.EX_flush);
    end

    assign bus.PC_Write     = !stall;
    assign bus.IF_ID_Write  = !stall;
    assign bus.ID_EX_Bubble = bubble;
    assign bus.Stall_count  = stall_cnt_q;

    // Shadow pipeline: EX takes ID or a bubble, older slots shift down every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= bubble ? '0 : id_slot;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating count of cycles lost to load-use stalls (flushed cycles excluded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    fwd_select u_fwd_a (
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .ex_src        (ex_q.rs1),
        .ex_use_src    (ex_q.use_rs1),
        .sel           (bus.ForwardA)
    );

    fwd_select u_fwd_b (
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .ex_src        (ex_q.rs2),
        .ex_use_src    (ex_q.use_rs2),
        .sel           (bus.ForwardB)
    );

    // Fields carried for completeness but not consulted once an instruction leaves EX.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2, mem_q.mem_read,
                                wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read};

endmodule
